// File: rtl/mem_bridge_pkg.sv
// ----------------------------------------------------------------------------
// mem_bridge_pkg
// Shared definitions for the word-to-block memory bridge:
//   - state_t    : bridge FSM state encoding
//   - BLOCK_W    : memory block width in bits (256)
//   - WORD_W     : CPU word width in bits (32)
//   - WORDS      : words per block
//   - WIDX_W     : width of the word index inside a block
//   - block_word : extracts word n (bits [32n+31:32n]) from a block
// ----------------------------------------------------------------------------
package mem_bridge_pkg;

  localparam int BLOCK_W = 256;
  localparam int WORD_W  = 32;
  localparam int WORDS   = BLOCK_W / WORD_W;
  localparam int WIDX_W  = $clog2(WORDS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    RSP  = 3'd3,
    WR   = 3'd4
  } state_t;

  function automatic logic [WORD_W-1:0] block_word(
    input logic [BLOCK_W-1:0] blk,
    input logic [WIDX_W-1:0]  idx
  );
    return blk[idx*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/block_word_merge.sv
// ----------------------------------------------------------------------------
// block_word_merge
// Purely combinational byte-enable merge of one CPU word into a memory block.
// Ports:
//   block_i    : original block
//   word_idx_i : which word of the block is addressed
//   wdata_i    : store data
//   be_i       : byte enables, bit b covers wdata_i[8b+7:8b]
//   block_o    : block with the enabled bytes of the addressed word replaced
// ----------------------------------------------------------------------------
module block_word_merge
  import mem_bridge_pkg::*;
(
  input  logic [BLOCK_W-1:0]  block_i,
  input  logic [WIDX_W-1:0]   word_idx_i,
  input  logic [WORD_W-1:0]   wdata_i,
  input  logic [WORD_W/8-1:0] be_i,
  output logic [BLOCK_W-1:0]  block_o
);

  for (genvar w = 0; w < WORDS; w++) begin : g_word
    localparam logic [WIDX_W-1:0] W_IDX = WIDX_W'(w);
    for (genvar b = 0; b < WORD_W / 8; b++) begin : g_byte
      assign block_o[w*WORD_W + b*8 +: 8] =
        ((word_idx_i == W_IDX) && be_i[b]) ? wdata_i[b*8 +: 8]
                                           : block_i[w*WORD_W + b*8 +: 8];
    end
  end

endmodule

// File: rtl/block_mem_bridge.sv
// ----------------------------------------------------------------------------
// block_mem_bridge
// Bridges single 32-bit CPU load/store requests onto a 256-bit block memory.
// Every access reads the whole block (readmem), then either returns the
// addressed word (load) or writes back the byte-merged block (store).
//
// Optional feature, macro BLOCK_BUF_EN: a one-entry block buffer (data, tag,
// valid). Loads that hit it complete one cycle after acceptance with no
// memory read. Stores always write through and refresh the buffer.
//
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_valid / req_ready : CPU request handshake. A request is taken on a
//                           rising edge where both are high. req_ready is high
//                           only in IDLE; req_valid is ignored elsewhere and
//                           nothing is queued.
//   req_write, req_addr, req_wdata, req_be : request payload
//   rsp_valid, rsp_rdata  : one-cycle completion pulse and load data (no
//                           backpressure)
//   block_addr            : block index, req_addr[BLOCK_ADDR_W+4:5]
//   readmem, writemem     : block memory read / write strobes
//   data_write, data_read : block write data / block read data (data_read is
//                           valid the cycle after readmem)
//   dbg_state             : current FSM state for observation
// ----------------------------------------------------------------------------
module block_mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int BLOCK_ADDR_W = 9
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [WORD_W-1:0]       req_wdata,
  input  logic [WORD_W/8-1:0]     req_be,
  output logic                    rsp_valid,
  output logic [WORD_W-1:0]       rsp_rdata,
  output logic [BLOCK_ADDR_W-1:0] block_addr,
  output logic                    readmem,
  output logic                    writemem,
  output logic [BLOCK_W-1:0]      data_write,
  input  logic [BLOCK_W-1:0]      data_read,
  output state_t                  dbg_state
);

  state_t                  state_q;
  logic                    write_q;
  logic [WIDX_W-1:0]       widx_q;
  logic [WORD_W-1:0]       wdata_q;
  logic [WORD_W/8-1:0]     be_q;
  logic [BLOCK_ADDR_W-1:0] block_addr_q;
  logic                    readmem_q;
  logic                    writemem_q;
  logic                    rsp_valid_q;
  logic [WORD_W-1:0]       rsp_rdata_q;
  logic [BLOCK_W-1:0]      data_write_q;
  logic [BLOCK_W-1:0]      merged;

`ifdef BLOCK_BUF_EN
  logic [BLOCK_W-1:0]      buf_q;
  logic [BLOCK_ADDR_W-1:0] buf_tag_q;
  logic                    buf_valid_q;
  logic                    buf_hit;

  assign buf_hit = buf_valid_q && !req_write &&
                   (buf_tag_q == req_addr[BLOCK_ADDR_W+4:5]);
`endif

  // Byte offset bits and address bits above the block index carry no meaning
  // for this bridge (assumes BLOCK_ADDR_W + 5 <= 31).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:BLOCK_ADDR_W+5]};

  // The merge always sees the block that memory returns during CAP.
  block_word_merge u_merge (
    .block_i    (data_read),
    .word_idx_i (widx_q),
    .wdata_i    (wdata_q),
    .be_i       (be_q),
    .block_o    (merged)
  );

  // Every output below is a register except req_ready, a direct state decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      widx_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      block_addr_q <= '0;
      readmem_q    <= 1'b0;
      writemem_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      data_write_q <= '0;
`ifdef BLOCK_BUF_EN
      buf_q        <= '0;
      buf_tag_q    <= '0;
      buf_valid_q  <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle; default them low every cycle.
      readmem_q   <= 1'b0;
      writemem_q  <= 1'b0;
      rsp_valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q      <= req_write;
            widx_q       <= req_addr[4:2];
            wdata_q      <= req_wdata;
            be_q         <= req_be;
            block_addr_q <= req_addr[BLOCK_ADDR_W+4:5];
`ifdef BLOCK_BUF_EN
            if (buf_hit) begin
              // Load served from the buffer: skip the memory read entirely.
              state_q     <= RSP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= block_word(buf_q, req_addr[4:2]);
            end else
`endif
            begin
              state_q   <= RD;
              readmem_q <= 1'b1;
            end
          end
        end

        RD: begin
          // readmem is high in this cycle; data_read arrives during CAP.
          state_q <= CAP;
        end

        CAP: begin
          rsp_valid_q <= 1'b1;
          if (write_q) begin
            // be == 0 still writes the block back, just unchanged.
            data_write_q <= merged;
            writemem_q   <= 1'b1;
            state_q      <= WR;
          end else begin
            rsp_rdata_q <= block_word(data_read, widx_q);
            state_q     <= RSP;
          end
`ifdef BLOCK_BUF_EN
          buf_q       <= write_q ? merged : data_read;
          buf_tag_q   <= block_addr_q;
          buf_valid_q <= 1'b1;
`endif
        end

        RSP, WR: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign block_addr = block_addr_q;
  assign readmem    = readmem_q;
  assign writemem   = writemem_q;
  assign data_write = data_write_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/block_mem_bridge.md
BLOCK_MEM_BRIDGE -- requirements
Module: block_mem_bridge

Interface
REQ-001 SHALL have parameter BLOCK_ADDR_W, default 9: width of block_addr and number of byte-address bits above bit 4 used for it.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1: CPU-side word request present.
REQ-005 SHALL have port req_ready, output, 1: bridge can accept a request.
REQ-006 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_addr, input, 32: byte address; bits [1:0] ignored.
REQ-008 SHALL have port req_wdata, input, 32: store data.
REQ-009 SHALL have port req_be, input, 4: store byte enables; bit i covers req_wdata[8i+7:8i].
REQ-010 SHALL have port rsp_valid, output, 1: one-cycle completion pulse; no backpressure.
REQ-011 SHALL have port rsp_rdata, output, 32: load data, valid when rsp_valid=1.
REQ-012 SHALL have port block_addr, output, BLOCK_ADDR_W: block index to main memory.
REQ-013 SHALL have ports readmem (output, 1), writemem (output, 1), data_write (output, 256) and data_read (input, 256): memory-side block interface; data_read is valid the cycle after readmem is high.

Function
REQ-014 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1, capturing addr, write, wdata and be.
REQ-015 SHALL drive req_ready=1 only in state IDLE.
REQ-016 SHALL use block_addr=req_addr[BLOCK_ADDR_W+4:5] and word index=req_addr[4:2]; word n occupies block bits [32n+31:32n].
REQ-017 SHALL sequence IDLE -> RD (readmem=1) -> CAP -> RSP (load) or WR (store) -> IDLE, with no waits.
REQ-018 SHALL, in CAP, register the selected word of data_read for loads, or the block with enabled bytes replaced by req_wdata for stores.
REQ-019 SHALL, for loads, assert rsp_valid in RSP, 3 cycles after acceptance.
REQ-020 SHALL, for stores, assert writemem=1 with the merged data_write and rsp_valid=1 together in WR, 3 cycles after acceptance.
REQ-021 SHALL never assert readmem and writemem in the same cycle.
REQ-022 SHALL hold block_addr stable from RD through WR/RSP.
REQ-023 SHALL treat a store with req_be=4'b0000 as a full read-then-write of the unchanged block.
REQ-024 SHALL ignore req_valid in every state except IDLE; requests are never queued.

Reset
REQ-025 SHALL, while reset_n=0, force state IDLE and drive req_ready=1, rsp_valid=0, readmem=0, writemem=0, rsp_rdata=0, data_write=0, block_addr=0.
REQ-026 SHALL abort any operation in progress on reset assertion; a store not yet in WR SHALL NOT reach memory.

Configuration
REQ-027 SHALL, with BLOCK_BUF_EN defined, hold one 256-bit block buffer with tag and valid bit, filled on every CAP and updated by every store merge.
REQ-028 SHALL, with BLOCK_BUF_EN defined, complete a load that hits a valid buffer in state RSP, 1 cycle after acceptance, without asserting readmem.
REQ-029 SHALL, with BLOCK_BUF_EN defined, clear the valid bit on reset; stores always write through to memory.
REQ-030 SHALL, without BLOCK_BUF_EN, contain no buffer and have 3-cycle latency for all accesses.

Structure
REQ-031 SHALL take the state enum, BLOCK_W=256 and WORD_W=32 from a shared package, mem_bridge_pkg.
REQ-032 SHALL place the byte-enable merge in a sub-module block_word_merge (block, word index, wdata, be -> block).

Verification
REQ-033 SHALL cover a load of 0x0000_0024 after memory block 1 is preloaded with word1=0xDEADBEEF: block_addr=1, readmem for 1 cycle, rsp_rdata=0xDEADBEEF 3 cycles later.
REQ-034 SHALL cover a store to 0x48 with wdata=0x11223344 and be=4'b0101 over block 2 word 2 = 0xAABBCCDD: writemem for 1 cycle and word becomes 0xAA22CC44.
REQ-035 SHALL cover req_valid held high through a load: exactly one acceptance, and req_ready stays low for 3 cycles.
REQ-036 SHALL cover reset_n pulsed low during CAP of a store: writemem never asserts and all outputs are at reset values.
REQ-037 SHALL cover, with BLOCK_BUF_EN, two loads to block 3: the second gets rsp_valid 1 cycle after acceptance with no readmem.
REQ-038 SHALL cover address 0x3FE0: block_addr=0x1FF, word 0.
